// File: rtl/reg_op_pkg.sv
// Shared definitions for the register-op sequencer: widths, opcodes, FSM states.
package reg_op_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_LDI = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ_A = 3'd1,
    ST_READ_B = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4
  } state_t;

endpackage

// File: rtl/reg_op_alu.sv
// Combinational ALU used in the EXEC step: ADD/SUB/AND on the two operands, LDI passes the immediate.
module reg_op_alu
  import reg_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] res,
  output logic              c
);

  logic [DATA_W:0] sum;

  // Result and carry/borrow; carry is only meaningful for ADD and SUB
  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        res = sum[DATA_W-1:0];
        c   = sum[DATA_W];
      end
      OP_SUB: begin
        res = a - b;
        c   = (a < b);
      end
      OP_AND: res = a & b;
      OP_LDI: res = imm;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_op_sequencer.sv
// Sequencer that reads up to two registers, runs the ALU and writes the result back to the register file.
module reg_op_sequencer
  import reg_op_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src_a,
  input  logic [ADDR_W-1:0] cmd_src_b,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              flag_c,
  output logic              flag_z
);

  state_t            state, state_nxt;
  logic              accept;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] dst_q, src_a_q, src_b_q;
  logic [DATA_W-1:0] imm_q, opa, opb, res_q;
  logic              c_q;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign accept = cmd_valid & cmd_ready;

  reg_op_alu #(.DATA_W(DATA_W)) u_alu (
    .op  (op_q),
    .a   (opa),
    .b   (opb),
    .imm (imm_q),
    .res (alu_res),
    .c   (alu_c)
  );

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and register-file port drive; ports rest at zero outside their active state
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rf_raddr  = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (accept) state_nxt = (op_t'(cmd_op) == OP_LDI) ? ST_EXEC : ST_READ_A;
      end
      ST_READ_A: begin
        rf_raddr  = src_a_q;
        state_nxt = ST_READ_B;
      end
      ST_READ_B: begin
        rf_raddr  = src_b_q;
        state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_WRITE;
      ST_WRITE: begin
        rf_we     = 1'b1;
        rf_waddr  = dst_q;
        rf_wdata  = res_q;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the command fields on the accepting edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      imm_q   <= '0;
    end else if (accept) begin
      op_q    <= cmd_op;
      dst_q   <= cmd_dst;
      src_a_q <= cmd_src_a;
      src_b_q <= cmd_src_b;
      imm_q   <= cmd_imm;
    end
  end

  // Capture operands during the read states and the ALU output during EXEC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa   <= '0;
      opb   <= '0;
      res_q <= '0;
      c_q   <= 1'b0;
    end else begin
      if (state == ST_READ_A) opa <= rf_rdata;
      if (state == ST_READ_B) opb <= rf_rdata;
      if (state == ST_EXEC) begin
        res_q <= alu_res;
        c_q   <= alu_c;
      end
    end
  end

  // Visible result and flags follow the write-back and hold until the next one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else if (state == ST_WRITE) begin
      result <= res_q;
      flag_c <= c_q;
      flag_z <= (res_q == '0);
    end
  end

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Initiator for the 4x8 register file port. Drives read address, write enable, write address and write data, and samples read data.
- Accepts one register-to-register command at a time over a valid/ready handshake. For each command it reads up to two operands, computes an 8-bit result, writes it back, and reports flags.
- Sits between the instruction decode stage and the register file.

Parameters:
- DATA_W, 8, register and datapath width.
- ADDR_W, 2, register address width (2**ADDR_W registers).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 LDI.
- cmd_dst  in  ADDR_W  destination register.
- cmd_src_a  in  ADDR_W  operand A register.
- cmd_src_b  in  ADDR_W  operand B register.
- cmd_imm  in  DATA_W  immediate, used by LDI only.
- rf_raddr  out  ADDR_W  register file read address.
- rf_rdata  in  DATA_W  register file read data; combinational from rf_raddr, same cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- done  out  1  one-cycle pulse, coincident with the write-back cycle.
- result  out  DATA_W  last written value; held until the next write-back.
- flag_c  out  1  carry/borrow of last op; held.
- flag_z  out  1  result == 0 of last op; held.

Behaviour:
- Reset: state=IDLE; cmd_ready=1. rf_we, done, result, flag_c, flag_z, rf_raddr, rf_waddr and rf_wdata are all 0. Internal operand and command registers are cleared to 0.
- Handshake: a command is accepted on a rising edge with cmd_valid & cmd_ready. At that edge op, dst, src_a, src_b and imm are latched. cmd_ready=0 in every state except IDLE; cmd_valid while busy is ignored and not queued.
- States: IDLE, READ_A, READ_B, EXEC, WRITE.
- IDLE -> READ_A on accept of ADD, SUB or AND. IDLE -> EXEC on accept of LDI.
- READ_A: rf_raddr=src_a; capture rf_rdata into opa at the end of the cycle; -> READ_B.
- READ_B: rf_raddr=src_b; capture rf_rdata into opb; -> EXEC.
- EXEC: compute res and c, register them; -> WRITE.
  - ADD: {c,res} = opa + opb, 9-bit.
  - SUB: res = opa - opb mod 2**DATA_W; c = (opa < opb), i.e. borrow.
  - AND: res = opa & opb; c = 0.
  - LDI: res = imm; c = 0.
- WRITE: rf_we=1, rf_waddr=dst, rf_wdata=res, done=1 for exactly one cycle. result, flag_c and flag_z (res==0) update at the end of this cycle; -> IDLE.
- rf_raddr=0 outside READ_A and READ_B. rf_we=0 outside WRITE.
- Latency, counting the accept edge as cycle 0:
  - ADD/SUB/AND: READ_A cycle 1, READ_B cycle 2, EXEC cycle 3, WRITE/done cycle 4, cmd_ready high again in cycle 5.
  - LDI: EXEC cycle 1, WRITE cycle 2, cmd_ready in cycle 3.
- Back-to-back: a command accepted in cycle 5 that reads the register just written sees the new value, because the register file updated at the end of cycle 4. No forwarding is needed.
- src_a == src_b is legal: the same register is read twice. dst equal to a source is legal: the write occurs after both reads.
- Reset asserted mid-operation: immediate return to IDLE; any pending write is discarded, with no rf_we pulse; flags and result are cleared.
- No wrap detection beyond flag_c; ADD overflow wraps mod 256.

Decomposition:
- Shared package reg_op_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_AND, OP_LDI;
  - state encoding constants for IDLE, READ_A, READ_B, EXEC, WRITE;
  - DATA_W and ADDR_W defaults.
- One combinational sub-module reg_op_alu(op, a, b, imm -> res, c), instantiated in the EXEC path.
- The FSM, operand registers and port drivers stay in the top module.

Test Plan:
- Reset, then LDI r1=0x05 and LDI r2=0x03, then ADD r0=r1+r2 -> on the ADD: rf_raddr 1 in cycle 1, 2 in cycle 2; rf_we with waddr=0, wdata=0x08 in cycle 4; done pulse; flag_c=0, flag_z=0.
- LDI r1=0xF0, LDI r2=0x20, ADD r3=r1+r2 -> wdata=0x10, flag_c=1, flag_z=0.
- SUB r0=r2-r1 with r1=0x05, r2=0x03 -> wdata=0xFE, flag_c=1. Then SUB r0=r1-r1 -> wdata=0x00, flag_z=1, flag_c=0.
- Hold cmd_valid high with a second command during busy cycles 1-4 -> cmd_ready=0 and no second accept until cycle 5. Back-to-back ADD r1=r1+r1 twice with r1=0x05 -> writes 0x0A then 0x14.
- Assert reset in the EXEC cycle of an ADD -> no rf_we pulse; r-file contents unchanged; outputs 0; cmd_ready=1 the cycle after reset deasserts.
- AND r2=r1&r3 with r1=0xF0, r3=0x3C -> wdata=0x30, flag_c=0. LDI r0=0x00 -> flag_z=1, done 2 cycles after accept.
